// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b cache types plus the L2 line responder's beat type and state encoding.
package lc3b_types;

  localparam int unsigned LC3B_WORD_W           = 16;
  localparam int unsigned LC3B_LINE_W           = 128;
  localparam int unsigned LC3B_BEAT_W           = 32;
  localparam int unsigned LC3B_BEATS            = 4;
  localparam int unsigned LC3B_LINE_OFFSET_BITS = 4;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;
  typedef logic [LC3B_BEAT_W-1:0] lc3b_beat;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BEAT = 3'd1,
    RD_GAP  = 3'd2,
    WR_BEAT = 3'd3,
    WR_GAP  = 3'd4,
    DONE    = 3'd5
  } l2_resp_state_e;

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage, written whole or one beat at a time, read one beat at a time.
module line_beat_buffer
  import lc3b_types::*;
#(
  parameter int unsigned BEATS  = LC3B_BEATS,
  parameter int unsigned BEAT_W = LC3B_BEAT_W,
  localparam int unsigned IDX_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  lc3b_line          i_line,
  input  logic              i_insert,
  input  logic [IDX_W-1:0]  i_ins_idx,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic [IDX_W-1:0]  i_sel_idx,
  output lc3b_line          o_line_nxt_c,
  output logic [BEAT_W-1:0] o_sel_beat_c
);

  lc3b_line r_line;
  lc3b_line w_line_nxt;

  // Next line value: clear beats load, load beats insert.
  always_comb begin
    w_line_nxt = r_line;
    if (i_clear) begin
      w_line_nxt = '0;
    end else if (i_load) begin
      w_line_nxt = i_line;
    end else if (i_insert) begin
      w_line_nxt[32'(i_ins_idx) * BEAT_W +: BEAT_W] = i_beat;
    end
  end

  // Line storage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line <= '0;
    end else begin
      r_line <= w_line_nxt;
    end
  end

  assign o_line_nxt_c = w_line_nxt;
  assign o_sel_beat_c = r_line[32'(i_sel_idx) * BEAT_W +: BEAT_W];

endmodule

// File: rtl/l2_line_responder.sv
// Serves one 128-bit L1 line request as BEATS narrow pmem bursts, then pulses l2_resp.
module l2_line_responder
  import lc3b_types::*;
#(
  parameter int unsigned BEATS  = LC3B_BEATS,
  parameter int unsigned BEAT_W = LC3B_BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l2_read,
  input  logic              l2_write,
  input  lc3b_word          l2_address,
  input  lc3b_line          l2_wdata,
  output lc3b_line          l2_rdata,
  output logic              l2_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output lc3b_word          pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned CNT_W      = $clog2(BEATS);
  localparam int unsigned BYTE_OFS_W = LC3B_LINE_OFFSET_BITS - CNT_W;
  localparam int unsigned TAG_W      = LC3B_WORD_W - LC3B_LINE_OFFSET_BITS;

  l2_resp_state_e    r_state;
  l2_resp_state_e    w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [TAG_W-1:0]  r_line_addr;
  logic [TAG_W-1:0]  w_tag_src;
  logic              w_last;
  logic              w_accept;
  logic              w_accept_wr;
  logic              w_insert;
  logic              w_rdata_load;
  logic              w_pmem_read_nxt;
  logic              w_pmem_write_nxt;
  lc3b_word          w_pmem_addr_nxt;
  logic [BEAT_W-1:0] w_pmem_wdata_nxt;
  lc3b_line          w_buf_line_nxt;
  logic [BEAT_W-1:0] w_sel_beat;
  logic              w_unused_addr_lsbs;

  lc3b_line          r_l2_rdata;
  logic              r_l2_resp;
  logic              r_pmem_read;
  logic              r_pmem_write;
  lc3b_word          r_pmem_address;
  logic [BEAT_W-1:0] r_pmem_wdata;

  // Byte offset within the line is never used: the whole line always moves.
  assign w_unused_addr_lsbs = ^l2_address[LC3B_LINE_OFFSET_BITS-1:0];

  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  // Line storage; read accept clears it, write accept loads the requester's line.
  line_beat_buffer #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_buf (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_accept & ~w_accept_wr),
    .i_load       (w_accept_wr),
    .i_line       (l2_wdata),
    .i_insert     (w_insert),
    .i_ins_idx    (r_cnt),
    .i_beat       (pmem_rdata),
    .i_sel_idx    (w_cnt_nxt),
    .o_line_nxt_c (w_buf_line_nxt),
    .o_sel_beat_c (w_sel_beat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, datapath controls and next values of the registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_accept         = 1'b0;
    w_accept_wr      = 1'b0;
    w_insert         = 1'b0;
    w_rdata_load     = 1'b0;
    w_tag_src        = r_line_addr;
    w_pmem_read_nxt  = 1'b0;
    w_pmem_write_nxt = 1'b0;
    w_pmem_addr_nxt  = '0;
    w_pmem_wdata_nxt = '0;

    unique case (r_state)
      IDLE: begin
        if (l2_read) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = RD_BEAT;
        end else if (l2_write) begin
          w_accept    = 1'b1;
          w_accept_wr = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WR_BEAT;
        end
      end
      RD_BEAT: begin
        if (pmem_resp) begin
          w_insert = 1'b1;
          if (w_last) begin
            w_rdata_load = 1'b1;
            w_state_nxt  = DONE;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = RD_GAP;
          end
        end
      end
      RD_GAP:  w_state_nxt = RD_BEAT;
      WR_BEAT: begin
        if (pmem_resp) begin
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = WR_GAP;
          end
        end
      end
      WR_GAP:  w_state_nxt = WR_BEAT;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // On the accept cycle the line address and first beat come straight from the request.
    if (w_accept) begin
      w_tag_src = l2_address[LC3B_WORD_W-1:LC3B_LINE_OFFSET_BITS];
    end
    w_pmem_read_nxt  = (w_state_nxt == RD_BEAT);
    w_pmem_write_nxt = (w_state_nxt == WR_BEAT);
    if (w_pmem_read_nxt || w_pmem_write_nxt) begin
      w_pmem_addr_nxt = {w_tag_src, w_cnt_nxt, BYTE_OFS_W'(0)};
    end
    if (w_pmem_write_nxt) begin
      w_pmem_wdata_nxt = w_accept ? l2_wdata[BEAT_W-1:0] : w_sel_beat;
    end
  end

  // Beat counter, latched line address and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_line_addr    <= '0;
      r_l2_rdata     <= '0;
      r_l2_resp      <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_line_addr    <= w_tag_src;
      r_l2_resp      <= (w_state_nxt == DONE);
      r_pmem_read    <= w_pmem_read_nxt;
      r_pmem_write   <= w_pmem_write_nxt;
      r_pmem_address <= w_pmem_addr_nxt;
      r_pmem_wdata   <= w_pmem_wdata_nxt;
      if (w_rdata_load) begin
        r_l2_rdata <= w_buf_line_nxt;
      end
    end
  end

  assign l2_rdata     = r_l2_rdata;
  assign l2_resp      = r_l2_resp;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: vector table plus hand-written corner sequences.
module tb_l2_line_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         l2_read, l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [31:0]  pmem_wdata;
  logic [31:0]  pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l2_line_responder dut (
    .clk          (clk),
    .reset        (reset),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  typedef struct {
    string        name;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           hold;
    logic         noise;
    logic [127:0] mem;
    int           lat;
    logic [15:0]  base;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  int n_pass  = 0;
  int n_total = 0;

  // Memory model and observation state.
  int           cyc = 0;
  int           hold = 1;
  logic         noise = 1'b0;
  logic [127:0] mem_line = '0;
  logic [15:0]  addr_log[$];
  logic [31:0]  wdata_log[$];
  int           resp_cnt, resp_cyc, rd_cyc_cnt, wr_cyc_cnt, gap_viol, first_wr_cyc;
  int           hold_cnt = 0;
  logic [127:0] rdata_at_resp;
  logic         prev_resp = 1'b0;
  logic         drop_rd = 1'b1, drop_wr = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_logs();
    addr_log.delete();
    wdata_log.delete();
    resp_cnt     = 0;
    resp_cyc     = -1;
    rd_cyc_cnt   = 0;
    wr_cyc_cnt   = 0;
    gap_viol     = 0;
    first_wr_cyc = -1;
    prev_resp    = 1'b0;
    rdata_at_resp = '0;
  endtask

  // One clock: observe outputs at the falling edge, then drive the memory response.
  task automatic cycle();
    logic strobe;
    int   idx;
    @(negedge clk);
    cyc++;
    strobe = (pmem_read === 1'b1) || (pmem_write === 1'b1);
    if (pmem_read === 1'b1) rd_cyc_cnt++;
    if (pmem_write === 1'b1) begin
      wr_cyc_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (strobe && prev_resp) gap_viol++;
    if (l2_resp === 1'b1) begin
      resp_cnt++;
      resp_cyc      = cyc;
      rdata_at_resp = l2_rdata;
      if (drop_rd) l2_read = 1'b0;
      if (drop_wr) l2_write = 1'b0;
    end
    if (strobe) begin
      hold_cnt++;
      if (hold_cnt >= hold) begin
        idx        = int'(pmem_address[3:2]);
        pmem_resp  = 1'b1;
        pmem_rdata = mem_line[idx*32 +: 32];
        addr_log.push_back(pmem_address);
        if (pmem_write === 1'b1) wdata_log.push_back(pmem_wdata);
        hold_cnt = 0;
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0BAD0BAD;
      end
    end else begin
      hold_cnt   = 0;
      pmem_resp  = noise;
      pmem_rdata = 32'hBADBAD00;
    end
    prev_resp = pmem_resp && strobe;
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    clear_logs();
    hold     = v.hold;
    noise    = v.noise;
    mem_line = v.mem;
    drop_rd  = 1'b1;
    drop_wr  = 1'b1;
    cycle();
    l2_read    = v.rd;
    l2_write   = v.wr;
    l2_address = v.addr;
    l2_wdata   = v.wdata;
    t0 = cyc;
    cycle();
    // Post-accept request changes must have no effect.
    l2_address = 16'h5A5A;
    l2_wdata   = ~v.wdata;
    for (int k = 0; k < 200 && resp_cnt == 0; k++) cycle();
    repeat (4) cycle();
    noise = 1'b0;
    check({v.name, " resp_count"}, resp_cnt, 1);
    check({v.name, " latency"}, resp_cyc - t0, v.lat);
    check({v.name, " beat_count"}, addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < addr_log.size())
        check($sformatf("%s addr%0d", v.name, i), addr_log[i], v.base + 16'(4 * i));
    check({v.name, " strobe_cycles"}, v.rd ? rd_cyc_cnt : wr_cyc_cnt, 4 * v.hold);
    check({v.name, " other_strobe"}, v.rd ? wr_cyc_cnt : rd_cyc_cnt, 0);
    check({v.name, " gap"}, gap_viol, 0);
    if (v.wr && !v.rd) begin
      for (int i = 0; i < 4; i++)
        if (i < wdata_log.size())
          check($sformatf("%s wdata%0d", v.name, i), wdata_log[i], v.wdata[i*32 +: 32]);
    end else begin
      check({v.name, " rdata_at_resp"}, rdata_at_resp, v.exp_rdata);
    end
    check({v.name, " rdata_hold"}, l2_rdata, v.exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic hit;
    logic [127:0] m_sim, w_sim;

    vecs[0] = '{"rd_zero_wait", 1'b1, 1'b0, 16'h1234, 128'h0, 1, 1'b0,
                128'h44444444_33333333_22222222_11111111, 8, 16'h1230,
                128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{"rd_wait3", 1'b1, 1'b0, 16'hFFF0, 128'h0, 3, 1'b0,
                128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 16, 16'hFFF0,
                128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1};
    vecs[2] = '{"wr_zero_wait", 1'b0, 1'b1, 16'h0040,
                128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1, 1'b0, 128'h0, 8, 16'h0040,
                128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1};
    vecs[3] = '{"wr_wait2_noise", 1'b0, 1'b1, 16'h0F0F,
                128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 2, 1'b1, 128'h0, 12, 16'h0F00,
                128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1};
    vecs[4] = '{"rd_offF_noise", 1'b1, 1'b0, 16'h000F, 128'h0, 2, 1'b1,
                128'h55AA55AA_AA55AA55_00FF00FF_FF00FF00, 12, 16'h0000,
                128'h55AA55AA_AA55AA55_00FF00FF_FF00FF00};

    reset      = 1'b1;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    clear_logs();
    repeat (3) cycle();
    check("rst l2_rdata", l2_rdata, 0);
    check("rst l2_resp", l2_resp, 0);
    check("rst pmem_read", pmem_read, 0);
    check("rst pmem_write", pmem_write, 0);
    check("rst pmem_address", pmem_address, 0);
    check("rst pmem_wdata", pmem_wdata, 0);
    reset = 1'b0;
    cycle();

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Simultaneous read and write: read first, write follows two cycles after l2_resp.
    m_sim = 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1;
    w_sim = 128'h77777777_66666666_55555555_44444444;
    clear_logs();
    hold = 1; mem_line = m_sim; drop_rd = 1'b1; drop_wr = 1'b0;
    cycle();
    l2_read = 1'b1; l2_write = 1'b1; l2_address = 16'h0080; l2_wdata = w_sim;
    for (int k = 0; k < 200 && resp_cnt == 0; k++) cycle();
    check("both wr_during_read", wr_cyc_cnt, 0);
    check("both read_beats", rd_cyc_cnt, 4);
    check("both rdata", l2_rdata, m_sim);
    drop_wr = 1'b1;
    for (int k = 0; k < 200 && resp_cnt < 2; k++) cycle();
    repeat (3) cycle();
    check("both write_start", first_wr_cyc - resp_cyc + (resp_cyc - first_wr_cyc) + (first_wr_cyc >= 0 ? 0 : 1000), 0);
    check("both resp_count", resp_cnt, 2);
    check("both wr_beats", wdata_log.size(), 4);
    if (wdata_log.size() == 4) begin
      check("both wdata0", wdata_log[0], w_sim[31:0]);
      check("both wdata3", wdata_log[3], w_sim[127:96]);
    end
    if (addr_log.size() == 8) check("both wr_addr0", addr_log[4], 16'h0080);
    check("both rdata_after_write", l2_rdata, m_sim);

    // Write must start exactly two cycles after the read's l2_resp: redo with a tracked resp cycle.
    begin
      int r1;
      clear_logs();
      hold = 1; mem_line = m_sim; drop_rd = 1'b1; drop_wr = 1'b0;
      cycle();
      l2_read = 1'b1; l2_write = 1'b1; l2_address = 16'h0080; l2_wdata = w_sim;
      for (int k = 0; k < 200 && resp_cnt == 0; k++) cycle();
      r1 = resp_cyc;
      drop_wr = 1'b1;
      for (int k = 0; k < 200 && resp_cnt < 2; k++) cycle();
      check("both write_gap", first_wr_cyc - r1, 2);
    end

    // Reset during beat 2 of a read.
    clear_logs();
    hold = 2; mem_line = 128'h99999999_88888888_77777777_66666666;
    drop_rd = 1'b1; drop_wr = 1'b1;
    cycle();
    l2_read = 1'b1; l2_address = 16'h2000;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (pmem_read === 1'b1 && pmem_address === 16'h2008 && hold_cnt == 1) begin
        hit = 1'b1;
        break;
      end
    end
    check("rstmid reached_beat2", hit, 1);
    reset = 1'b1;
    cycle();
    check("rstmid pmem_read", pmem_read, 0);
    check("rstmid pmem_address", pmem_address, 0);
    check("rstmid l2_rdata", l2_rdata, 0);
    check("rstmid l2_resp", l2_resp, 0);
    reset = 1'b0;
    l2_read = 1'b0;
    resp_cnt = 0;
    repeat (8) cycle();
    check("rstmid no_resp", resp_cnt, 0);
    check("rstmid idle_strobes", rd_cyc_cnt, 2 * 2 + 1);

    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
